hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 16-bit core. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register. It resolves four conditions: load-use hazards (with a parameterised stall length), taken branches, data-memory back-pressure and halt/resume requests. It sits beside the decode stage and is the sole source of the IF/ID `RegWrite` enable.

## Interface
- `LOAD_LAT`, 1, stall cycles inserted per load-use hazard (1..7)
- `DRAIN_CYCLES`, 3, cycles waited after halt request before asserting `Halted` (1..7)
- `REG_AW`, 4, register-index width
- `CLK` in 1: single clock, rising edge
- `Reset` in 1: asynchronous, active-low reset
- `EX_MemRead` in 1: instruction in EX is a load
- `EX_Rd` in REG_AW: destination register of the EX instruction
- `ID_Rs1`, `ID_Rs2` in REG_AW: source registers of the ID instruction
- `ID_UsesRs1`, `ID_UsesRs2` in 1: the ID instruction actually reads that source
- `BranchTaken` in 1: the branch/jump in EX redirects the PC this cycle
- `MemBusy` in 1: data memory not ready; the pipeline must freeze
- `HaltReq` in 1: single-cycle halt request
- `Resume` in 1: single-cycle resume request
- `PCWrite` out 1: PC load enable
- `IFIDWrite` out 1: IF/ID write enable (drives IF_ID `RegWrite`)
- `IFIDFlush` out 1: IF/ID loads zero next edge
- `IDEXWrite` out 1: ID/EX write enable
- `IDEXBubble` out 1: ID/EX loads a NOP next edge
- `Halted` out 1: core halted
- `StallCount` out 16: saturating count of stalled cycles

## Operation
- FSM states: RUN, STALL, DRAIN, HALT. Registered state plus a 3-bit counter. Outputs are combinational from state and inputs.
- Load-use hazard (`lu`) = `EX_MemRead` & `EX_Rd`≠0 & ((`ID_UsesRs1` & `ID_Rs1`==`EX_Rd`) | (`ID_UsesRs2` & `ID_Rs2`==`EX_Rd`)).
- Default outputs in RUN: `PCWrite`=`IFIDWrite`=`IDEXWrite`=1; flush and bubble outputs 0.
- Priority inside RUN, highest first: `MemBusy`, `BranchTaken`, `lu`, `HaltReq`.
- `MemBusy`=1 in any state except HALT:
  - `PCWrite`=`IFIDWrite`=`IDEXWrite`=0; flush and bubble outputs 0.
  - State and counter hold.
  - All other events that cycle are ignored. `HaltReq` is lost.
- `BranchTaken` in RUN: `PCWrite`=1, `IFIDFlush`=1, `IDEXBubble`=1. State stays RUN.
- `lu` in RUN:
  - `PCWrite`=`IFIDWrite`=0, `IDEXBubble`=1.
  - If `LOAD_LAT`>1: go to STALL with counter=`LOAD_LAT`-1. Otherwise stay in RUN.
- STALL:
  - Outputs are the same as the `lu` cycle.
  - Counter decrements each non-`MemBusy` cycle.
  - When counter==1 at a clock edge, next state is RUN.
  - `BranchTaken` and `HaltReq` are ignored.
- `HaltReq` in RUN (no higher event): go to DRAIN with counter=`DRAIN_CYCLES`.
- DRAIN:
  - `PCWrite`=0, `IFIDWrite`=1, `IFIDFlush`=1. The ID/EX path is unchanged.
  - Counter decrements. At 1, next state is HALT.
  - `BranchTaken` in DRAIN: `IDEXBubble`=1 only; PC stays frozen.
- HALT:
  - All write enables 0, `Halted`=1.
  - `MemBusy` is ignored.
  - `Resume` moves to RUN next edge. `Resume` in any other state is ignored.
- `StallCount` increments on every edge where `Reset`=1, state≠HALT and `PCWrite`=0. It saturates at 16'hFFFF.

## Timing
- `Reset` low asynchronously forces:
  - state RUN, counter 0, `StallCount`=0.
  - All outputs 0 (`PCWrite`, `IFIDWrite`, `IDEXWrite`, `IFIDFlush`, `IDEXBubble`, `Halted`).
- First RUN outputs appear combinationally after `Reset` rises.
- Reset mid-STALL, mid-DRAIN or in HALT aborts immediately. No stall cycles remain afterwards.
- Hazard and branch responses are same-cycle (zero latency): they take effect at the next `CLK` edge.
- A load-use hazard costs exactly `LOAD_LAT` cycles with `PCWrite`=0, plus any `MemBusy` cycles.
- Halt: `Halted` rises `DRAIN_CYCLES`+1 edges after the `HaltReq` edge.
- Simultaneous `BranchTaken` and `lu`: branch wins, no stall.
- Simultaneous `lu` and `HaltReq`: stall taken; `HaltReq` is dropped.

## Test plan
- Reset check: `Reset`=0 mid-run → all outputs 0, `StallCount`=0. Release reset with no hazards → `PCWrite`=`IFIDWrite`=`IDEXWrite`=1.
- Load-use, `LOAD_LAT`=2: `EX_MemRead`=1, `EX_Rd`=3, `ID_Rs2`=3, `ID_UsesRs2`=1 → 2 cycles of `PCWrite`=0 with `IDEXBubble`=1, then RUN, `StallCount`=2. Same stimulus with `EX_Rd`=0 → no stall.
- Branch/hazard collision: `BranchTaken`=1 in the same cycle as the load-use hazard → `IFIDFlush`=`IDEXBubble`=1, `PCWrite`=1, no stall.
- Memory back-pressure: `MemBusy` high for 3 cycles during STALL → all enables 0 for those cycles, stall counter held, STALL finishes afterwards, `StallCount` increases by 5 (`LOAD_LAT`=2).
- Halt/resume, `DRAIN_CYCLES`=3: `HaltReq` pulse → 3 cycles with `IFIDFlush`=1 and `PCWrite`=0, then `Halted`=1. `Resume` pulse → RUN next edge, `Halted`=0.
- Reset during DRAIN → immediate RUN-reset values; no `Halted` afterwards.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use stalls, taken branches,
// data-memory back-pressure and halt/resume, driving PC / IF/ID / ID/EX controls.
module hazard_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_AW       = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic [REG_AW-1:0] ID_Rs1,
  input  logic [REG_AW-1:0] ID_Rs2,
  input  logic              ID_UsesRs1,
  input  logic              ID_UsesRs2,
  input  logic              BranchTaken,
  input  logic              MemBusy,
  input  logic              HaltReq,
  input  logic              Resume,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              IDEXWrite,
  output logic              IDEXBubble,
  output logic              Halted,
  output logic [15:0]       StallCount,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_stall_cnt;

  logic [1:0]  w_state_nx;
  logic [2:0]  w_cnt_nx;
  logic        w_lu;
  logic        w_pcw, w_ifidw, w_ifidf, w_idexw, w_idexb, w_halted;

  assign w_lu = EX_MemRead && (EX_Rd != '0) &&
                ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                 (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

  always_comb begin
    w_pcw      = 1'b1;
    w_ifidw    = 1'b1;
    w_ifidf    = 1'b0;
    w_idexw    = 1'b1;
    w_idexb    = 1'b0;
    w_halted   = 1'b0;
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      RUN: begin
        if (MemBusy) begin
          w_pcw   = 1'b0;
          w_ifidw = 1'b0;
          w_idexw = 1'b0;
        end else if (BranchTaken) begin
          w_ifidf = 1'b1;
          w_idexb = 1'b1;
        end else if (w_lu) begin
          w_pcw   = 1'b0;
          w_ifidw = 1'b0;
          w_idexb = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_nx = STALL;
            w_cnt_nx   = LOAD_RELOAD;
          end
        end else if (HaltReq) begin
          w_state_nx = DRAIN;
          w_cnt_nx   = DRAIN_RELOAD;
        end
      end
      STALL: begin
        w_pcw   = 1'b0;
        w_ifidw = 1'b0;
        if (MemBusy) begin
          w_idexw = 1'b0;
        end else begin
          w_idexb = 1'b1;
          if (r_cnt == 3'd1) begin
            w_state_nx = RUN;
            w_cnt_nx   = 3'd0;
          end else begin
            w_cnt_nx = r_cnt - 3'd1;
          end
        end
      end
      DRAIN: begin
        w_pcw = 1'b0;
        if (MemBusy) begin
          w_ifidw = 1'b0;
          w_idexw = 1'b0;
        end else begin
          // PC stays frozen even on a branch; only the ID/EX slot is squashed.
          w_ifidf = 1'b1;
          w_idexb = BranchTaken;
          if (r_cnt == 3'd1) begin
            w_state_nx = HALT;
            w_cnt_nx   = 3'd0;
          end else begin
            w_cnt_nx = r_cnt - 3'd1;
          end
        end
      end
      default: begin
        w_pcw    = 1'b0;
        w_ifidw  = 1'b0;
        w_idexw  = 1'b0;
        w_halted = 1'b1;
        if (Resume) w_state_nx = RUN;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just at the edge.
  assign PCWrite     = Reset & w_pcw;
  assign IFIDWrite   = Reset & w_ifidw;
  assign IFIDFlush   = Reset & w_ifidf;
  assign IDEXWrite   = Reset & w_idexw;
  assign IDEXBubble  = Reset & w_idexb;
  assign Halted      = Reset & w_halted;
  assign StallCount  = r_stall_cnt;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= RUN;
      r_cnt       <= 3'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if ((r_state != HALT) && !w_pcw && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=2, DRAIN_CYCLES=3); per-cycle
// expected controls and StallCount go through a queue checked on the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_memread = 1'b0;
  logic [3:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        branch_taken = 1'b0, mem_busy = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, halted;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state;

  logic [21:0] exp_q[$];
  int          id_q[$];
  int          tests = 0;
  int          fails = 0;
  int          step_no = 0;

  // control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, Halted}
  localparam logic [5:0] C_RUN   = 6'b110100;
  localparam logic [5:0] C_LU    = 6'b000110;
  localparam logic [5:0] C_BR    = 6'b111110;
  localparam logic [5:0] C_DRAIN = 6'b011100;
  localparam logic [5:0] C_DRBR  = 6'b011110;
  localparam logic [5:0] C_HALT  = 6'b000001;
  localparam logic [5:0] C_ZERO  = 6'b000000;

  hazard_ctrl #(.LOAD_LAT(2), .DRAIN_CYCLES(3), .REG_AW(4)) dut (
    .CLK(clk), .Reset(rst_n),
    .EX_MemRead(ex_memread), .EX_Rd(ex_rd),
    .ID_Rs1(id_rs1), .ID_Rs2(id_rs2),
    .ID_UsesRs1(id_uses_rs1), .ID_UsesRs2(id_uses_rs2),
    .BranchTaken(branch_taken), .MemBusy(mem_busy),
    .HaltReq(halt_req), .Resume(resume),
    .PCWrite(pc_write), .IFIDWrite(ifid_write), .IFIDFlush(ifid_flush),
    .IDEXWrite(idex_write), .IDEXBubble(idex_bubble), .Halted(halted),
    .StallCount(stall_count), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ev = {BranchTaken, MemBusy, HaltReq, Resume}; uses = {UsesRs1, UsesRs2}
  task automatic step(input logic rst, input logic mr, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [1:0] uses, input logic [3:0] ev,
                      input logic [5:0] exp_ctrl, input logic [15:0] exp_cnt);
    @(posedge clk);
    #1;
    rst_n        = rst;
    ex_memread   = mr;
    ex_rd        = rd;
    id_rs1       = rs1;
    id_rs2       = rs2;
    {id_uses_rs1, id_uses_rs2} = uses;
    {branch_taken, mem_busy, halt_req, resume} = ev;
    step_no++;
    exp_q.push_back({exp_ctrl, exp_cnt});
    id_q.push_back(step_no);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] exp_v;
      logic [21:0] got_v;
      int          id;
      exp_v = exp_q.pop_front();
      id    = id_q.pop_front();
      got_v = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, halted, stall_count};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL step%0d: ctrl=%b cnt=%0d state=%0d, expected ctrl=%b cnt=%0d",
                 id, got_v[21:16], got_v[15:0], dbg_state, exp_v[21:16], exp_v[15:0]);
      end
    end
  end

  initial begin
    //     rst mr rd  rs1 rs2 uses   ev       ctrl     cnt
    step(0, 0, 0, 0, 0, 2'b00, 4'b0000, C_ZERO,  0);   // held in reset
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);   // first RUN outputs
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);
    step(1, 1, 3, 1, 3, 2'b01, 4'b0000, C_LU,    0);   // load-use via rs2
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_LU,    1);   // STALL cycle
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   2);
    step(1, 1, 0, 1, 0, 2'b01, 4'b0000, C_RUN,   2);   // EX_Rd=0: no hazard
    step(1, 1, 3, 1, 3, 2'b01, 4'b1000, C_BR,    2);   // branch beats load-use
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   2);
    step(1, 1, 3, 1, 3, 2'b01, 4'b0000, C_LU,    2);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0100, C_ZERO,  3);   // MemBusy during STALL
    step(1, 0, 0, 0, 0, 2'b00, 4'b0100, C_ZERO,  4);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0100, C_ZERO,  5);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_LU,    6);   // STALL resumes
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   7);   // +5 total
    step(1, 1, 3, 1, 3, 2'b01, 4'b0010, C_LU,    7);   // lu + halt: halt dropped
    step(1, 0, 0, 0, 0, 2'b00, 4'b0010, C_LU,    8);   // halt ignored in STALL
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   9);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0110, C_ZERO,  9);   // busy swallows halt
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,  10);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0010, C_RUN,  10);   // halt request
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_DRAIN,10);
    step(1, 0, 0, 0, 0, 2'b00, 4'b1000, C_DRBR, 11);   // branch while draining
    step(1, 0, 0, 0, 0, 2'b00, 4'b0001, C_DRAIN,12);   // resume ignored in DRAIN
    step(1, 0, 0, 0, 0, 2'b00, 4'b0100, C_HALT, 13);   // busy ignored in HALT
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_HALT, 13);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0001, C_HALT, 13);   // resume
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,  13);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0010, C_RUN,  13);   // halt again
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_DRAIN,13);
    step(0, 0, 0, 0, 0, 2'b00, 4'b0000, C_ZERO,  0);   // reset mid-DRAIN
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   0);   // no Halted after abort
    step(1, 1, 5, 5, 0, 2'b00, 4'b0000, C_RUN,   0);   // match but rs1 unused
    step(1, 1, 5, 5, 0, 2'b10, 4'b0000, C_LU,    0);   // load-use via rs1
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_LU,    1);
    step(1, 0, 0, 0, 0, 2'b00, 4'b0000, C_RUN,   2);
    step(1, 0, 5, 5, 5, 2'b11, 4'b0000, C_RUN,   2);   // not a load
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
